// File: rtl/acc_trace_capture.sv
// Watches the accumulator bus, queues every changed value in a small FIFO and
// flags when the value has settled. Define CAPTURE_DELTA_EN to queue deltas instead of absolute values.
module acc_trace_capture #(
  parameter int DW            = 6,
  parameter int DEPTH         = 4,
  parameter int STABLE_CYCLES = 8,
  parameter int EXPECT        = 33
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            w_in,
  output logic [DW-1:0]            out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     match,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [DW-1:0] EXP_W   = DW'(EXPECT);
  localparam logic [CW-1:0] CNT_TOP = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_END = CW'(STABLE_CYCLES - 1);

  typedef enum logic {TRACK, SETTLED} state_t;

  logic [DW-1:0] w_prev;
  logic [DW-1:0] push_word;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          chg, full, pop, push, drop;

  state_t        state, state_nxt;
  logic [CW-1:0] stable_cnt, cnt_nxt;
  logic          match_q, match_nxt;

  assign chg       = (w_in != w_prev);
  assign full      = (level == LW'(DEPTH));
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a change when the head leaves in the same cycle.
  assign push      = chg && (!full || pop);
  assign drop      = chg && full && !pop;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

`ifdef CAPTURE_DELTA_EN
  assign push_word = w_in - w_prev;
`else
  assign push_word = w_in;
`endif

  // FIFO control and change-detect history
  always_ff @(posedge clk) begin
    if (reset) begin
      w_prev   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      w_prev <= w_in;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  // Settle-detect state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= TRACK;
      stable_cnt <= '0;
      match_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      stable_cnt <= cnt_nxt;
      match_q    <= match_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = stable_cnt;
    match_nxt = match_q;
    case (state)
      TRACK: begin
        if (chg) begin
          cnt_nxt = '0;
        end else begin
          if (stable_cnt != CNT_TOP) cnt_nxt = stable_cnt + 1'b1;
          if (stable_cnt == CNT_END) begin
            state_nxt = SETTLED;
            match_nxt = (w_in == EXP_W);
          end
        end
      end
      SETTLED: begin
        if (chg) begin
          state_nxt = TRACK;
          cnt_nxt   = '0;
          match_nxt = 1'b0;
        end
      end
      default: state_nxt = TRACK;
    endcase
  end

  always_comb begin
    done  = (state == SETTLED);
    match = (state == SETTLED) && match_q;
  end

endmodule

// File: tb/tb_acc_trace_capture.sv
// Randomized and directed bench for acc_trace_capture against a queue-based
// reference model that tracks run lengths of unchanged input.
module tb_acc_trace_capture;

  localparam int DW            = 6;
  localparam int DEPTH         = 4;
  localparam int STABLE_CYCLES = 8;
  localparam int EXPECT        = 33;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DW-1:0]          w_in;
  logic [DW-1:0]          out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   done;
  logic                   match;
  logic                   overflow;
  logic [$clog2(DEPTH):0] level;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_prev;
  bit            m_ovf;
  int            m_run;

  acc_trace_capture #(
    .DW(DW), .DEPTH(DEPTH), .STABLE_CYCLES(STABLE_CYCLES), .EXPECT(EXPECT)
  ) dut (
    .clk(clk), .reset(reset), .w_in(w_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .done(done), .match(match),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the reference behaviour, using the inputs just applied.
  task automatic model_edge(input bit rst, input logic [DW-1:0] w, input bit rdy);
    bit chg, was_full, popped;
    logic [DW-1:0] word;
    if (rst) begin
      mq.delete();
      m_prev = '0;
      m_ovf  = 0;
      m_run  = 0;
      return;
    end
    chg      = (w != m_prev);
    was_full = (mq.size() == DEPTH);
    popped   = (mq.size() > 0) && rdy;
    if (popped) void'(mq.pop_front());
`ifdef CAPTURE_DELTA_EN
    word = w - m_prev;
`else
    word = w;
`endif
    if (chg) begin
      if (was_full && !popped) m_ovf = 1;
      else mq.push_back(word);
      m_run = 0;
    end else begin
      m_run++;
    end
    m_prev = w;
  endtask

  task automatic compare_outputs();
    bit exp_done;
    exp_done = (m_run >= STABLE_CYCLES);
    check_eq("out_valid", out_valid, mq.size() > 0);
    check_eq("out_data",  out_data,  (mq.size() > 0) ? mq[0] : '0);
    check_eq("level",     level,     mq.size());
    check_eq("done",      done,      exp_done);
    check_eq("match",     match,     exp_done && (m_prev == DW'(EXPECT)));
    check_eq("overflow",  overflow,  m_ovf);
  endtask

  task automatic cycle(input bit rst, input logic [DW-1:0] w, input bit rdy);
    reset     = rst;
    w_in      = w;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rst, w, rdy);
    @(negedge clk);
    compare_outputs();
  endtask

  // Upstream accumulate sequence: each value held for 'hold' cycles, then 33 held long.
  task automatic upstream_run(input bit rdy, input int hold);
    int seqv[7] = '{1, 2, 4, 7, 12, 20, 33};
    for (int i = 0; i < 7; i++)
      for (int k = 0; k < ((i == 6) ? 12 : hold); k++)
        cycle(1'b0, DW'(seqv[i]), rdy);
  endtask

  initial begin
    int hold;
    bit rdy_bias;
    logic [DW-1:0] w;

    cycle(1'b1, '0, 1'b1);
    cycle(1'b1, '0, 1'b1);

    // normal drain, then settle with a match
    upstream_run(1'b1, 5);

    // stalled sink: fill, overflow, then drain
    cycle(1'b1, '0, 1'b0);
    upstream_run(1'b0, 5);
    for (int k = 0; k < 8; k++) cycle(1'b0, 6'd33, 1'b1);

    // fill to full, then change with pop in the same cycle
    cycle(1'b1, '0, 1'b0);
    for (int v = 1; v <= 4; v++) cycle(1'b0, DW'(v * 3), 1'b0);
    cycle(1'b0, 6'd40, 1'b1);
    cycle(1'b0, 6'd40, 1'b0);

    // mid-operation reset with data queued and settled
    cycle(1'b1, '0, 1'b0);
    for (int v = 1; v <= 3; v++) cycle(1'b0, DW'(v + 30), 1'b0);
    for (int k = 0; k < STABLE_CYCLES + 1; k++) cycle(1'b0, 6'd33, 1'b0);
    cycle(1'b1, 6'd33, 1'b0);
    cycle(1'b0, 6'd5, 1'b1);
    cycle(1'b0, 6'd5, 1'b1);

    // randomized traffic with occasional resets and long holds
    for (int it = 0; it < 300; it++) begin
      w        = ($urandom_range(0, 3) == 0) ? DW'(EXPECT) : DW'($urandom_range(0, 63));
      hold     = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 14) : $urandom_range(1, 4);
      rdy_bias = $urandom_range(0, 1);
      for (int k = 0; k < hold; k++)
        cycle($urandom_range(0, 150) == 0, w,
              rdy_bias ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_trace_capture.md
Name: acc_trace_capture

Overview:
Downstream consumer of the 6-bit accumulator result bus W, which the hard-wired accumulate sequencer drives. The block watches W every cycle and pushes each new value into a small FIFO. Software or the next stage drains the FIFO over a valid/ready interface. The block also detects when the accumulator has settled and checks the final value against an expected constant.

Parameters:
DW, 6, data width of w_in and out_data
DEPTH, 4, FIFO entries (power of 2, ≥2)
STABLE_CYCLES, 8, consecutive unchanged cycles required to declare settled (≥1)
EXPECT, 33, expected final accumulator value for match

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
w_in  in  DW  accumulator value from upstream, sampled every posedge
out_data  out  DW  head-of-FIFO sample
out_valid  out  1  out_data is valid
out_ready  in  1  sink accepts out_data this cycle
done  out  1  accumulator settled
match  out  1  settled value equals EXPECT (valid only while done=1)
overflow  out  1  sticky: a change was dropped because the FIFO was full
level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. Every state element is sampled on posedge clk.
- Reset values: w_prev=0, FIFO empty, level=0, out_valid=0, out_data=0, done=0, match=0, overflow=0, stable_cnt=0, state=TRACK.
- Change detect: chg = (w_in != w_prev). w_prev <= w_in every cycle.
- Push on chg: the pushed word is w_in.
- Latency: a value that differs on cycle N is visible at the FIFO head no earlier than cycle N+1. If the FIFO was empty, out_valid=1 on N+1.
- Pop: a pop occurs when out_valid && out_ready.
- Stall: out_data and out_valid stay stable while out_valid && !out_ready.
- FIFO pointers: read and write pointers wrap modulo DEPTH. level is updated as +1 on push only, -1 on pop only, and unchanged on both or neither.
- Full with chg and pop in the same cycle: the push is accepted and level stays DEPTH.
- Full with chg and no pop: the sample is dropped and overflow <= 1. overflow is sticky until reset.
- Empty with chg and out_ready=1 in the same cycle: no bypass. The pop is ignored because out_valid=0, and the data appears next cycle.
- FSM states:
  - TRACK: stable_cnt <= chg ? 0 : stable_cnt+1 (saturating). When !chg and stable_cnt == STABLE_CYCLES-1, go to SETTLED, set done<=1 and match<=(w_in==EXPECT).
  - SETTLED: done=1 and match is held. On chg, go to TRACK, set done<=0, match<=0, stable_cnt<=0, and push normally.
- Reset asserted mid-operation: all state returns to reset values on that edge. Queued FIFO data is discarded and w_prev=0.
- Arithmetic: all compares are DW bits, unsigned. stable_cnt is $clog2(STABLE_CYCLES+1) bits wide.

Optional Feature:
Macro: CAPTURE_DELTA_EN
- Defined: the pushed word is (w_in - w_prev) mod 2^DW, not w_in. Change detection, done and match are unchanged; match still compares the absolute w_in.
- Undefined: the pushed word is the absolute w_in.

Test Plan:
1. Upstream sequencer connected, reset for 2 cycles, out_ready=1 → out_data stream 1,2,4,7,12,20,33. Then done=1 8 cycles after 33 appears, with match=1, overflow=0.
2. Same as case 1 with CAPTURE_DELTA_EN defined → stream 1,1,2,3,5,8,13, done=1, match=1.
3. out_ready=0 throughout the upstream run → level reaches 4 holding 1,2,4,7. The later changes 12,20,33 are dropped and overflow=1. Then set out_ready=1 → 1,2,4,7 drain, level=0, overflow stays 1.
4. STABLE_CYCLES=4 with the upstream run → done=1 and match=0 during the 5-cycle hold of 20. When 33 arrives, done drops to 0 in the next cycle and the FSM returns to TRACK. After 4 stable cycles, done=1 and match=1.
5. FIFO full, then w_in changes while out_ready=1 in the same cycle → head pops, new value enqueued, level stays 4, overflow=0.
6. Assert reset for 1 cycle while level=3 and done=1 → next cycle out_valid=0, level=0, done=0, match=0, overflow=0. A w_in of 5 then produces out_data=5.
